// File: rtl/register_file_pkg.sv
// Shared types and default parameters for the register file and its bus read sequencer.
// Sequencer states: IDLE (no result), PTR (indirect pointer held), RESP (result on the bus).
package register_file_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  function automatic logic high_bits_set(input logic [31:0] word, input int addr_width);
    return |(word >> addr_width);
  endfunction

endpackage

// File: rtl/register_file_read_seq.sv
// Bus read sequencer: direct reads take 1 cycle, indirect reads 2 cycles.
// Requests are ignored while busy (PTR); out data is tri-stated except in RESP.
module register_file_read_seq
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en,
  input  logic                  indirect_mode_en,
  input  logic [DATA_WIDTH-1:0] ry_data,
  input  logic [DATA_WIDTH-1:0] ptr_data,
  output logic [ADDR_WIDTH-1:0] ptr_sel,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_valid,
  output logic                  bus_error,
  output logic                  busy
);

  seq_state_t            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  err;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  busy_q;
  logic [31:0]           ry_wide;

  always_comb begin
    ry_wide                 = '0;
    ry_wide[DATA_WIDTH-1:0] = ry_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      err    <= 1'b0;
      data   <= '0;
      valid  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        PTR: begin
          // Pointed register is sampled pre-edge: a write in this cycle is not seen.
          data   <= ptr_data;
          valid  <= 1'b1;
          busy_q <= 1'b0;
          state  <= RESP;
        end
        default: begin
          if (read_en) begin
            if (indirect_mode_en) begin
              ptr    <= ry_data[ADDR_WIDTH-1:0];
              err    <= high_bits_set(ry_wide, ADDR_WIDTH);
              valid  <= 1'b0;
              busy_q <= 1'b1;
              state  <= PTR;
            end else begin
              data   <= ry_data;
              err    <= 1'b0;
              valid  <= 1'b1;
              busy_q <= 1'b0;
              state  <= RESP;
            end
          end else begin
            valid  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

  assign ptr_sel   = ptr;
  assign bus_valid = valid;
  assign bus_error = valid & err;
  assign busy      = busy_q;
  assign bus_data  = valid ? data : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/register_file.sv
// Register array with one write port, two combinational operand ports and a sequenced bus read port.
// Writes land in 1 edge and never stall; bus reads are handled by register_file_read_seq.
module register_file
  import register_file_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] in_rx_selector,
  input  logic [ADDR_WIDTH-1:0] in_ry_selector,
  input  logic                  in_indirect_mode_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_bus_data,
  output logic                  out_bus_valid,
  output logic                  out_bus_error,
  output logic                  out_busy,
  output logic [DATA_WIDTH-1:0] out_rx_data,
  output logic [DATA_WIDTH-1:0] out_ry_data
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] registers [NUM_REGS];
  logic [ADDR_WIDTH-1:0] ptr_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        registers[i] <= RESET_VALUE;
      end
    end else if (write_en) begin
      registers[in_rx_selector] <= in_data;
    end
  end

  assign out_rx_data = registers[in_rx_selector];
  assign out_ry_data = registers[in_ry_selector];

  register_file_read_seq #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_read_seq (
    .clk             (clk),
    .rst             (rst),
    .read_en         (read_en),
    .indirect_mode_en(in_indirect_mode_en),
    .ry_data         (registers[in_ry_selector]),
    .ptr_data        (registers[ptr_sel]),
    .ptr_sel         (ptr_sel),
    .bus_data        (out_bus_data),
    .bus_valid       (out_bus_valid),
    .bus_error       (out_bus_error),
    .busy            (out_busy)
  );

endmodule
